// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/stall controller producing stage enables and flushes for a 5-stage MIPS pipeline.
module pipe_ctrl #(
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dest_reg,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);
    localparam int WW = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2;

    logic [1:0]    state;
    logic [WW-1:0] wait_cnt;
    logic          run, done, miss, load_use;

    always_comb begin
        run      = state == RUN;
        done     = state == MEM_WAIT && mem_ready;
        miss     = mem_req && !mem_ready;
        load_use = ex_mem_read && ex_dest_reg != 5'd0 &&
                   (ex_dest_reg == id_rs || (id_uses_rt && ex_dest_reg == id_rt));
        // a miss masks branch and load-use; a branch masks load-use
        pc_en        = !reset && (run ? !(miss || (!branch_taken && load_use)) : done);
        if_id_en     = pc_en;
        id_ex_en     = !reset && (run ? !miss : done);
        ex_mem_en    = id_ex_en;
        if_id_flush  = !reset && run && !miss && branch_taken;
        id_ex_flush  = !reset && run && !miss && (branch_taken || load_use);
        mem_wb_flush = !reset && (run ? miss : !done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            if (!pc_en && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (run && miss) begin
                state    <= MEM_WAIT;
                wait_cnt <= WW'(1);
            end else if (state == MEM_WAIT) begin
                if (mem_ready)
                    state <= RUN;
                else if (wait_cnt == WW'(MAX_MEM_WAIT)) begin
                    state       <= ERROR;
                    mem_timeout <= 1'b1;
                end else
                    wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. It generates the per-stage enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It detects load-use hazards, applies branch-taken flushes, and freezes the pipeline while a data-memory access waits on its ready handshake. A memory-wait timeout is included, along with a saturating stall-cycle counter for performance measurement.

## Interface
- MAX_MEM_WAIT, 15: maximum number of consecutive MEM_WAIT cycles before a timeout (≥1).
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_dest_reg  in  5  destination register of the EX instruction.
- branch_taken  in  1  a branch resolved taken in EX this cycle.
- mem_req  in  1  the MEM stage performs a data-memory read or write this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID register loads zero (a NOP).
- id_ex_en  out  1  ID/EX register load enable.
- id_ex_flush  out  1  ID/EX register loads a bubble (all controls 0).
- ex_mem_en  out  1  EX/MEM register load enable.
- mem_wb_flush  out  1  MEM/WB register loads a bubble.
- mem_timeout  out  1  sticky error flag: memory wait exceeded MAX_MEM_WAIT.
- stall_count  out  CNT_W  saturating count of cycles in which pc_en=0.

## Operation
- States:
  - RUN: normal operation.
  - MEM_WAIT: pipeline frozen while a memory access completes.
  - ERROR: pipeline frozen after a memory-wait timeout.
- Outputs are combinational from the current state and inputs. Flush has priority over enable, so a flushed register loads the bubble.
- Default in RUN: pc_en, if_id_en, id_ex_en and ex_mem_en are 1; all flushes are 0.
- Memory miss, evaluated first in RUN:
  - Condition: mem_req=1 and mem_ready=0.
  - Outputs: pc_en, if_id_en, id_ex_en and ex_mem_en go to 0, and mem_wb_flush=1.
  - Branch and load-use logic are suppressed.
  - Next state is MEM_WAIT, with wait_cnt set to 1.
- Branch, evaluated in RUN with no memory miss:
  - Condition: branch_taken=1.
  - Outputs: if_id_flush=1 and id_ex_flush=1; all enables stay 1.
  - The branch masks load-use detection in the same cycle, because the ID instruction is being squashed.
- Load-use, evaluated in RUN with no memory miss and no branch:
  - Condition: ex_mem_read=1, ex_dest_reg≠0, and either ex_dest_reg==id_rs, or (id_uses_rt=1 and ex_dest_reg==id_rt).
  - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en stays 1.
  - This produces exactly one bubble; the state stays RUN.
- MEM_WAIT:
  - Outputs while waiting: all enables 0 and mem_wb_flush=1.
  - If mem_ready=1: outputs return to the RUN defaults for this cycle, with no flushes. Next state is RUN. Branch and load-use are not evaluated in this cycle; the frozen EX and ID instructions re-evaluate in the following cycle.
  - If mem_ready=0 and wait_cnt==MAX_MEM_WAIT: next state is ERROR and mem_timeout is set.
  - If mem_ready=0 otherwise: wait_cnt increments.
- ERROR:
  - Outputs are the same as MEM_WAIT.
  - mem_ready is ignored; only reset exits this state.
- stall_count increments on every clock edge where pc_en=0 and saturates at all-ones.
- wait_cnt has width clog2(MAX_MEM_WAIT+1).

## Timing
- Reset (asynchronous) sets state=RUN, wait_cnt=0, mem_timeout=0 and stall_count=0.
- While reset is high: all enables are 0, all flushes are 0, mem_timeout=0, stall_count=0.
- Load-use response: zero latency (same cycle). The bubble enters EX at the next edge and the dependent instruction is released one cycle later.
- Branch flush: applies at the edge that ends the cycle in which branch_taken is high.
- Memory miss of N cycles (mem_ready rising N cycles after mem_req): N cycles with pc_en=0, and stall_count advances by N.
- mem_ready=1 in the same cycle as mem_req: no stall.
- Timeout: mem_timeout rises at the edge following the MAX_MEM_WAIT-th MEM_WAIT cycle without ready.
- Reset mid-MEM_WAIT: returns to RUN immediately; wait_cnt is cleared.

## Test plan
- Load-use hazard:
  - Stimulus: ex_mem_read=1, ex_dest_reg=8, id_rs=8.
  - Required response: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle; stall_count becomes 1.
  - Same stimulus with ex_dest_reg=0 → no stall.
- rt dependence:
  - Stimulus: ex_dest_reg=9, id_rt=9.
  - Required response: with id_uses_rt=0 → no stall; with id_uses_rt=1 → 1-cycle stall.
- Branch with coincident load-use:
  - Stimulus: branch_taken=1 together with a load-use match.
  - Required response: if_id_flush=1 and id_ex_flush=1, pc_en=1, no stall; stall_count unchanged.
- Memory wait:
  - Stimulus: mem_req=1 with mem_ready=0 for 3 cycles, then 1.
  - Required response: freeze for 3 cycles with mem_wb_flush=1, release on the 4th cycle; stall_count=3; state returns to RUN.
- Timeout:
  - Stimulus: MAX_MEM_WAIT=4, mem_ready held at 0.
  - Required response: mem_timeout=1 after 5 frozen cycles; it stays set when mem_ready later rises; reset clears it.
- Asynchronous reset:
  - Stimulus: assert reset mid-MEM_WAIT, between clock edges.
  - Required response: outputs go to reset values immediately; after release, RUN defaults with pc_en=1.
